// File: rtl/lifo.sv
// LIFO stack: single-clock, registered pop data, flags decoded from the
// registered word count. Storage is indexed by the stack pointer, so the
// top of stack always lives at entry usedw-1.
//
// Request semantics (no handshake back-pressure; requests are qualified
// internally against the flags at the same edge):
//   wrreq_i only            -> push if not full, else silently ignored
//   rdreq_i only            -> pop if not empty (q_o valid next cycle), else ignored
//   wrreq_i and rdreq_i     -> if not empty: q_o <= top, top <= data_i, count held
//                              if empty:     treated as a plain push, q_o held
module lifo #(
    parameter int DWIDTH       = 16,
    parameter int AWIDTH       = 8,
    parameter int ALMOST_FULL  = 2,
    parameter int ALMOST_EMPTY = 2
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic              wrreq_i,
    input  logic [DWIDTH-1:0] data_i,
    input  logic              rdreq_i,
    output logic [DWIDTH-1:0] q_o,
    output logic              almost_empty_o,
    output logic              empty_o,
    output logic              almost_full_o,
    output logic              full_o,
    output logic [AWIDTH:0]   usedw_o
);

    localparam int DEPTH = 1 << AWIDTH;

    localparam logic [AWIDTH:0] DEPTH_W = (AWIDTH+1)'(DEPTH);
    localparam logic [AWIDTH:0] AF_W    = (AWIDTH+1)'(ALMOST_FULL);
    localparam logic [AWIDTH:0] AE_W    = (AWIDTH+1)'(ALMOST_EMPTY);

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AWIDTH:0]   usedw;
    logic [AWIDTH-1:0] top_addr;
    logic [AWIDTH-1:0] wr_addr;
    logic              empty;
    logic              full;
    logic              do_push;
    logic              do_pop;
    logic              do_swap;
    logic              mem_we;

    // Decode flags and the accepted operation for this cycle.
    always_comb begin
        empty    = (usedw == '0);
        full     = (usedw == DEPTH_W);
        top_addr = usedw[AWIDTH-1:0] - 1'b1;
        // A simultaneous request on an empty stack degrades to a push.
        do_push  = wrreq_i && (!rdreq_i || empty) && !full;
        do_pop   = rdreq_i && !wrreq_i && !empty;
        do_swap  = wrreq_i && rdreq_i && !empty;
        mem_we   = do_push || do_swap;
        wr_addr  = do_swap ? top_addr : usedw[AWIDTH-1:0];
    end

    // Storage write port; contents are intentionally not cleared by reset.
    always_ff @(posedge clk_i) begin
        if (srst_i && mem_we) begin
            mem[wr_addr] <= data_i;
        end
    end

    // Word count and registered pop data; reset overrides any request.
    always_ff @(posedge clk_i) begin
        if (!srst_i) begin
            usedw <= '0;
            q_o   <= '0;
        end else begin
            if (do_push) begin
                usedw <= usedw + 1'b1;
            end else if (do_pop) begin
                usedw <= usedw - 1'b1;
            end
            if (do_pop || do_swap) begin
                q_o <= mem[top_addr];
            end
        end
    end

    // Flag outputs follow the registered count on the same edge.
    always_comb begin
        usedw_o        = usedw;
        empty_o        = empty;
        full_o         = full;
        almost_empty_o = (usedw < AE_W);
        almost_full_o  = (usedw >= AF_W);
    end

endmodule

// File: tb/tb_lifo.sv
// Bench for lifo: a fixed vector table for short corner sequences, then
// randomized traffic checked against a queue-based stack model.
module tb_lifo;

    localparam int DW    = 16;
    localparam int AW    = 8;
    localparam int DEPTH = 256;

    logic          clk;
    logic          srst;
    logic          wrreq;
    logic          rdreq;
    logic [DW-1:0] data;
    logic [DW-1:0] q;
    logic          almost_empty;
    logic          empty;
    logic          almost_full;
    logic          full;
    logic [AW:0]   usedw;

    int checks = 0;
    int errors = 0;

    // Reference model: the stack contents (back = top) and the q_o value.
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_out;

    lifo #(
        .DWIDTH(DW), .AWIDTH(AW), .ALMOST_FULL(2), .ALMOST_EMPTY(2)
    ) dut (
        .clk_i(clk),
        .srst_i(srst),
        .wrreq_i(wrreq),
        .data_i(data),
        .rdreq_i(rdreq),
        .q_o(q),
        .almost_empty_o(almost_empty),
        .empty_o(empty),
        .almost_full_o(almost_full),
        .full_o(full),
        .usedw_o(usedw)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one edge and sample #1 later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Compare every output against the model.
    task automatic check_model(input string tag);
        int n;
        n = exp_q.size();
        chk({tag, " usedw"}, 32'(usedw), 32'(n));
        chk({tag, " q"}, 32'(q), 32'(exp_out));
        chk({tag, " empty"}, 32'(empty), 32'(n == 0));
        chk({tag, " full"}, 32'(full), 32'(n == DEPTH));
        chk({tag, " almost_empty"}, 32'(almost_empty), 32'(n < 2));
        chk({tag, " almost_full"}, 32'(almost_full), 32'(n >= 2));
    endtask

    // Drive one cycle, update the model from the stack rules, compare.
    task automatic apply(input string tag, input logic rst_n, input logic wr,
                         input logic rd, input logic [DW-1:0] d);
        srst  = rst_n;
        wrreq = wr;
        rdreq = rd;
        data  = d;
        if (!rst_n) begin
            exp_q.delete();
            exp_out = '0;
        end else if (wr && rd) begin
            if (exp_q.size() > 0) begin
                exp_out = exp_q[exp_q.size()-1];
                exp_q[exp_q.size()-1] = d;
            end else begin
                exp_q.push_back(d);
            end
        end else if (wr) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(d);
        end else if (rd) begin
            if (exp_q.size() > 0) exp_out = exp_q.pop_back();
        end
        step();
        check_model(tag);
    endtask

    typedef struct {
        logic          rst_n;
        logic          wr;
        logic          rd;
        logic [DW-1:0] d;
        logic [AW:0]   e_usedw;
        logic [DW-1:0] e_q;
        logic          e_empty;
        logic          e_full;
        logic          e_ae;
        logic          e_af;
    } vec_t;

    vec_t vecs[14];

    initial begin
        srst  = 1'b0;
        wrreq = 1'b0;
        rdreq = 1'b0;
        data  = '0;
        exp_out = '0;

        // Vector table: reset with a pending push, pops from empty,
        // A/B/C push, simultaneous D, pops, then push-only on empty.
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 16'h1234, 9'd0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 16'h0000, 9'd0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 16'h0000, 9'd0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 16'h0000, 9'd0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 16'h000a, 9'd1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 16'h000b, 9'd2, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 16'h000c, 9'd3, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 16'h000d, 9'd3, 16'h000c, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 16'h0000, 9'd2, 16'h000d, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 16'h0000, 9'd1, 16'h000b, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 16'h0000, 9'd0, 16'h000a, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 16'h0000, 9'd0, 16'h000a, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 1'b1, 16'h000e, 9'd1, 16'h000a, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 16'h0000, 9'd0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};

        for (int i = 0; i < 14; i++) begin
            srst  = vecs[i].rst_n;
            wrreq = vecs[i].wr;
            rdreq = vecs[i].rd;
            data  = vecs[i].d;
            step();
            chk($sformatf("vec%0d usedw", i), 32'(usedw), 32'(vecs[i].e_usedw));
            chk($sformatf("vec%0d q", i), 32'(q), 32'(vecs[i].e_q));
            chk($sformatf("vec%0d empty", i), 32'(empty), 32'(vecs[i].e_empty));
            chk($sformatf("vec%0d full", i), 32'(full), 32'(vecs[i].e_full));
            chk($sformatf("vec%0d almost_empty", i), 32'(almost_empty), 32'(vecs[i].e_ae));
            chk($sformatf("vec%0d almost_full", i), 32'(almost_full), 32'(vecs[i].e_af));
        end

        // Fill to capacity plus one ignored push, then drain plus one ignored pop.
        apply("fill_rst", 1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < DEPTH + 1; i++) begin
            apply("fill_push", 1'b1, 1'b1, 1'b0, DW'($urandom));
        end
        chk("full_at_256", 32'(full), 32'(1));
        chk("usedw_cap", 32'(usedw), 32'(DEPTH));
        // Simultaneous request while full: swap the top, count unchanged.
        apply("full_swap", 1'b1, 1'b1, 1'b1, DW'($urandom));
        for (int i = 0; i < DEPTH + 1; i++) begin
            apply("drain_pop", 1'b1, 1'b0, 1'b1, '0);
        end
        chk("empty_at_end", 32'(empty), 32'(1));

        // Random traffic on a pre-filled stack, with a reset mid-stream.
        for (int i = 0; i < 100; i++) begin
            apply("prefill", 1'b1, 1'b1, 1'b0, DW'($urandom));
        end
        for (int i = 0; i < 100; i++) begin
            int op;
            op = $urandom_range(0, 3);
            if (i == 60) begin
                apply("mid_reset", 1'b0, 1'($urandom), 1'($urandom), DW'($urandom));
                chk("mid_reset_usedw", 32'(usedw), 32'(0));
            end else begin
                apply("rand_op", 1'b1, op[0], op[1], DW'($urandom));
            end
        end
        while (exp_q.size() > 0) begin
            apply("rand_drain", 1'b1, 1'b0, 1'b1, '0);
        end
        apply("final_idle", 1'b1, 1'b0, 1'b0, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lifo.md
LIFO -- requirements
Module: lifo

Interface
REQ-001 The block SHALL have parameter DWIDTH, default 16, data word width in bits.
REQ-002 The block SHALL have parameter AWIDTH, default 8, address width; depth DEPTH = 2**AWIDTH words (256 by default).
REQ-003 The block SHALL have parameter ALMOST_FULL, default 2, the almost-full threshold in words.
REQ-004 The block SHALL have parameter ALMOST_EMPTY, default 2, the almost-empty threshold in words.
REQ-005 The block SHALL have port clk_i, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port srst_i, input, 1 bit, the reset; it is synchronous and active-low (0 = reset).
REQ-007 The block SHALL have port wrreq_i, input, 1 bit, the push request.
REQ-008 The block SHALL have port data_i, input, DWIDTH bits, the push data.
REQ-009 The block SHALL have port rdreq_i, input, 1 bit, the pop request.
REQ-010 The block SHALL have port q_o, output, DWIDTH bits, the registered pop data.
REQ-011 The block SHALL have port almost_empty_o, output, 1 bit.
REQ-012 The block SHALL have port empty_o, output, 1 bit.
REQ-013 The block SHALL have port almost_full_o, output, 1 bit.
REQ-014 The block SHALL have port full_o, output, 1 bit.
REQ-015 The block SHALL have port usedw_o, output, AWIDTH+1 bits, the count of stored words (0..DEPTH).

Function
REQ-016 Storage SHALL be a DEPTH x DWIDTH array indexed by the stack pointer: the top of stack is entry usedw-1.
REQ-017 A push SHALL be accepted when wrreq_i=1, rdreq_i=0 and full_o=0: data_i is written to entry usedw and usedw increments at the same edge.
REQ-018 A pop SHALL be accepted when rdreq_i=1, wrreq_i=0 and empty_o=0: q_o is loaded with entry usedw-1 at that edge, so data is valid one cycle after the request, and usedw decrements.
REQ-019 When wrreq_i=1, rdreq_i=1 and usedw>0, the block SHALL load q_o with the current top, overwrite the top entry with data_i and leave usedw unchanged; this also applies when full.
REQ-020 When wrreq_i=1, rdreq_i=1 and empty_o=1, the block SHALL treat the cycle as a push only and hold q_o.
REQ-021 A push while full (without rdreq_i) SHALL be ignored: storage and usedw are unchanged, and no error is flagged.
REQ-022 A pop while empty SHALL be ignored: usedw stays 0 and q_o holds its previous value.
REQ-023 q_o SHALL hold its value in every cycle without an accepted pop.
REQ-024 Flags SHALL be decoded from the registered usedw so they change on the same edge as usedw: empty_o = (usedw==0); full_o = (usedw==DEPTH); almost_empty_o = (usedw < ALMOST_EMPTY); almost_full_o = (usedw >= ALMOST_FULL).
REQ-025 usedw arithmetic SHALL be AWIDTH+1 bits wide and SHALL never wrap past 0 or DEPTH.

Reset
REQ-026 While srst_i=0 at a clock edge, the block SHALL set usedw_o=0, q_o=0, empty_o=1, almost_empty_o=1, full_o=0 and almost_full_o=0.
REQ-027 Reset SHALL take priority over wrreq_i and rdreq_i, including mid-operation; memory contents need not be cleared.
REQ-028 The block SHALL accept requests from the first edge after srst_i returns to 1.

Verification
REQ-029 Push 257 random words, then pop 257 times: q_o returns the words in reverse order (last pushed first); the 257th push is ignored; full_o=1 at usedw=256; the final extra pop leaves q_o unchanged; empty_o=1 at the end.
REQ-030 Pop 3 times from empty after reset: usedw_o stays 0, empty_o=1, q_o stays 0.
REQ-031 Push 256 words and hold wrreq_i=1 for one more cycle: usedw_o=256 and not greater; then 256 pops return the stored data in LIFO order.
REQ-032 Push words A, B, C, then assert wrreq_i and rdreq_i together with data D: next cycle q_o=C and usedw_o=3; a following pop returns D, then B, then A.
REQ-033 Walk usedw through 0, 1, 2, 255 and 256: almost_empty_o is 1 for usedw<2; almost_full_o is 1 for usedw>=2; empty_o and full_o are 1 only at 0 and 256 respectively.
REQ-034 Pre-fill 100 words, run 100 cycles of random idle/push/pop/simultaneous operations, drain, and compare against a software stack model, including the assertion of srst_i=0 mid-stream (usedw_o=0 on the next cycle).
